// File: rtl/rip_axi_slave_memory.sv
// AXI4 slave that turns one burst at a time into accesses on a single-port word-wide synchronous RAM.
// Define RIP_AXI_SLAVE_RANGE_CHECK_EN to answer bursts running past MEM_DEPTH with SLVERR instead of wrapping.
module rip_axi_slave_memory #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int MEM_AW    = $clog2(MEM_DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    // write address
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0]     s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // RAM port
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_re,
    output logic [STRB_W-1:0]     mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int OFF = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_REQ, R_CAP, R_DATA} state_t;

    state_t                state_reg;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [7:0]            len_reg;
    logic [7:0]            cnt_reg;
    logic [MEM_AW-1:0]     idx_reg;
    logic                  err_reg;
    logic                  live_reg;
    logic                  bvalid_reg;
    logic [ID_WIDTH-1:0]   bid_reg;
    logic [1:0]            bresp_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [ID_WIDTH-1:0]   rid_reg;
    logic [1:0]            rresp_reg;
    logic                  rlast_reg;

    logic aw_hs, ar_hs, w_hs;
    logic aw_err, ar_err;
    logic unused_bits;

    function automatic logic [MEM_AW-1:0] next_idx(input logic [MEM_AW-1:0] idx);
        return (idx == MEM_AW'(MEM_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

`ifdef RIP_AXI_SLAVE_RANGE_CHECK_EN
    // Last word of the burst, taken from the full address so aliasing above MEM_DEPTH is caught.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
        logic [ADDR_WIDTH:0] last_word;
        last_word = {1'b0, addr >> OFF} + {{(ADDR_WIDTH - 7){1'b0}}, len};
        return last_word >= (ADDR_WIDTH + 1)'(MEM_DEPTH);
    endfunction
    assign aw_err = out_of_range(s_axi_awaddr, s_axi_awlen);
    assign ar_err = out_of_range(s_axi_araddr, s_axi_arlen);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Size, burst type and WLAST play no part: full-width INCR is assumed and AWLEN ends the burst.
    assign unused_bits = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                           s_axi_wlast, s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = live_reg && (state_reg == IDLE);
    assign s_axi_arready = live_reg && (state_reg == IDLE) && !s_axi_awvalid;
    assign s_axi_wready  = (state_reg == W_DATA);
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    assign mem_addr  = idx_reg;
    assign mem_wdata = s_axi_wdata;
    assign mem_we    = (w_hs && !err_reg) ? s_axi_wstrb : '0;
    assign mem_re    = (state_reg == R_REQ) && !err_reg;

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bid    = bid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rid    = rid_reg;
    assign s_axi_rresp  = rresp_reg;
    assign s_axi_rlast  = rlast_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            id_reg     <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            err_reg    <= 1'b0;
            live_reg   <= 1'b0;
            bvalid_reg <= 1'b0;
            bid_reg    <= '0;
            bresp_reg  <= RESP_OKAY;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rid_reg    <= '0;
            rresp_reg  <= RESP_OKAY;
            rlast_reg  <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (aw_hs) begin
                        id_reg    <= s_axi_awid;
                        len_reg   <= s_axi_awlen;
                        idx_reg   <= s_axi_awaddr[MEM_AW+OFF-1:OFF];
                        cnt_reg   <= '0;
                        err_reg   <= aw_err;
                        state_reg <= W_DATA;
                    end else if (ar_hs) begin
                        id_reg    <= s_axi_arid;
                        len_reg   <= s_axi_arlen;
                        idx_reg   <= s_axi_araddr[MEM_AW+OFF-1:OFF];
                        cnt_reg   <= '0;
                        err_reg   <= ar_err;
                        state_reg <= R_REQ;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        idx_reg <= next_idx(idx_reg);
                        cnt_reg <= cnt_reg + 8'd1;
                        if (cnt_reg == len_reg) begin
                            bvalid_reg <= 1'b1;
                            bid_reg    <= id_reg;
                            bresp_reg  <= err_reg ? RESP_SLVERR : RESP_OKAY;
                            state_reg  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                R_REQ: state_reg <= R_CAP;
                R_CAP: begin
                    rdata_reg  <= err_reg ? '0 : mem_rdata;
                    rid_reg    <= id_reg;
                    rresp_reg  <= err_reg ? RESP_SLVERR : RESP_OKAY;
                    rlast_reg  <= (cnt_reg == len_reg);
                    rvalid_reg <= 1'b1;
                    state_reg  <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_reg <= 1'b0;
                        if (rlast_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= next_idx(idx_reg);
                            cnt_reg   <= cnt_reg + 8'd1;
                            state_reg <= R_REQ;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rip_axi_slave_memory.sv
// Directed bench for rip_axi_slave_memory with a behavioural RAM on the memory port.
// Expected read data for the wrap/range case follows RIP_AXI_SLAVE_RANGE_CHECK_EN.
module tb_rip_axi_slave_memory;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = 2'b01, arburst = 2'b01;
    logic        awvalid = 1'b0, arvalid = 1'b0, awready, arready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 1'b0;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready = 1'b0;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [1024] = '{default: '0};
    int compared = 0;
    int mismatched = 0;
    int re_count = 0;

    rip_axi_slave_memory dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
            re_count  <= re_count + 1;
        end
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    // Stimulus helpers: all start and end 1 time unit after a rising edge.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, output bit ok);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (awready) begin @(posedge clk); #1; ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, output bit ok);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (arready) begin @(posedge clk); #1; ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last,
                          output logic [3:0] we_seen, output logic [9:0] addr_seen,
                          output int waits, output bit ok);
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        ok = 1'b0; waits = 0; we_seen = '0; addr_seen = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (wready) begin
                we_seen = mem_we; addr_seen = mem_addr;
                @(posedge clk); #1; ok = 1'b1; break;
            end
            @(posedge clk); #1; waits++;
        end
        wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp, output int waits, output bit ok);
        bready = 1'b1; ok = 1'b0; waits = 0; id = '0; resp = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bvalid) begin id = bid; resp = bresp; @(posedge clk); #1; ok = 1'b1; break; end
            @(posedge clk); #1; waits++;
        end
        bready = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] d, output logic [3:0] id, output logic [1:0] resp,
                          output logic last, output int waits, output bit ok);
        rready = 1'b1; ok = 1'b0; waits = 0; d = '0; id = '0; resp = '0; last = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rvalid) begin
                d = rdata; id = rid; resp = rresp; last = rlast;
                @(posedge clk); #1; ok = 1'b1; break;
            end
            @(posedge clk); #1; waits++;
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({awready, arready, wready, bvalid, rvalid, mem_re, mem_we} !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl got=%b want=0", {awready, arready, wready, bvalid, rvalid, mem_re, mem_we});
        end
        compared++;
        if ({rdata, bid, rid, bresp, rresp, rlast, mem_addr} !== 63'd0) begin
            mismatched++;
            $display("FAIL reset_data rdata=%h bid=%h rid=%h bresp=%b rresp=%b rlast=%b addr=%h want all 0",
                     rdata, bid, rid, bresp, rresp, rlast, mem_addr);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_single_write_read();
        bit ok; logic [3:0] we, id; logic [9:0] a; int waits; logic [1:0] resp; logic [31:0] d; logic last;
        aw_send(4'h5, 32'h10, 8'd0, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL single_aw timeout got=%b want=1", ok); end
        w_send(32'hDEADBEEF, 4'hF, 1'b1, we, a, waits, ok);
        compared++; if ({ok, we, a} !== {1'b1, 4'hF, 10'd4}) begin
            mismatched++; $display("FAIL single_w ok=%b we=%h addr=%0d want ok=1 we=f addr=4", ok, we, a); end
        b_recv(id, resp, waits, ok);
        compared++; if ({ok, id, resp, waits} !== {1'b1, 4'h5, 2'b00, 32'd0}) begin
            mismatched++; $display("FAIL single_b ok=%b bid=%h bresp=%b waits=%0d want 1/5/00/0", ok, id, resp, waits); end
        $display("write id=5 addr=0x10 len=0 bresp=%b", resp);
        ar_send(4'h9, 32'h10, 8'd0, ok);
        r_recv(d, id, resp, last, waits, ok);
        compared++; if ({ok, d, id, resp, last} !== {1'b1, 32'hDEADBEEF, 4'h9, 2'b00, 1'b1}) begin
            mismatched++; $display("FAIL single_r ok=%b rdata=%h rid=%h rresp=%b rlast=%b want 1/deadbeef/9/00/1",
                                   ok, d, id, resp, last); end
        // RVALID in the third cycle after the AR handshake: two edges after the handshake edge.
        compared++; if (waits !== 2) begin mismatched++; $display("FAIL single_r_latency got=%0d want=2", waits); end
        $display("read id=9 addr=0x10 len=0 rdata=%h", d);
    endtask

    task automatic test_burst_backpressure();
        bit ok; logic [3:0] we, id; logic [9:0] a; int waits, re0; logic [1:0] resp; logic [31:0] d, held; logic last;
        logic [31:0] wd [4];
        logic [3:0]  ws [4];
        logic [31:0] exp [4];
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        ws[0] = 4'hF; ws[1] = 4'h1; ws[2] = 4'hF; ws[3] = 4'hC;
        exp[0] = 32'h11111111; exp[1] = 32'h00000022; exp[2] = 32'h33333333; exp[3] = 32'h44440000;
        aw_send(4'h3, 32'h0, 8'd3, ok);
        for (int i = 0; i < 4; i++) begin
            w_send(wd[i], ws[i], i == 3, we, a, waits, ok);
            compared++; if ({ok, we, a, waits} !== {1'b1, ws[i], 10'(i), 32'd0}) begin
                mismatched++; $display("FAIL burst_w%0d ok=%b we=%h addr=%0d waits=%0d want 1/%h/%0d/0",
                                       i, ok, we, a, waits, ws[i], i); end
        end
        b_recv(id, resp, waits, ok);
        compared++; if ({ok, id, resp} !== {1'b1, 4'h3, 2'b00}) begin
            mismatched++; $display("FAIL burst_b ok=%b bid=%h bresp=%b want 1/3/00", ok, id, resp); end
        $display("write id=3 addr=0x0 len=3 bresp=%b", resp);
        ar_send(4'hC, 32'h0, 8'd3, ok);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                ok = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    #1; if (rvalid) begin ok = 1'b1; break; end
                    @(posedge clk); #1;
                end
                held = rdata; re0 = re_count;
                compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL bp_rvalid timeout got=%b want=1", ok); end
                repeat (5) begin
                    @(posedge clk); #1;
                    compared++; if ({rvalid, rdata} !== {1'b1, held}) begin
                        mismatched++; $display("FAIL bp_hold rvalid=%b rdata=%h want 1/%h", rvalid, rdata, held); end
                end
                compared++; if (re_count !== re0) begin
                    mismatched++; $display("FAIL bp_no_re reads=%0d want=%0d", re_count, re0); end
            end
            r_recv(d, id, resp, last, waits, ok);
            compared++; if ({ok, d, id, resp, last} !== {1'b1, exp[i], 4'hC, 2'b00, i == 3}) begin
                mismatched++; $display("FAIL burst_r%0d ok=%b rdata=%h rid=%h rresp=%b rlast=%b want 1/%h/c/00/%0d",
                                       i, ok, d, id, resp, last, exp[i], i == 3); end
            $display("read beat %0d id=c rdata=%h rlast=%b", i, d, last);
        end
    endtask

    task automatic test_b_backpressure();
        bit ok; logic [3:0] we, id; logic [9:0] a; int waits; logic [1:0] resp;
        aw_send(4'h2, 32'h40, 8'd0, ok);
        w_send(32'hCAFEF00D, 4'hF, 1'b1, we, a, waits, ok);
        for (int k = 0; k < 4; k++) begin
            compared++; if ({bvalid, bid} !== {1'b1, 4'h2}) begin
                mismatched++; $display("FAIL b_hold%0d bvalid=%b bid=%h want 1/2", k, bvalid, bid); end
            @(posedge clk); #1;
        end
        b_recv(id, resp, waits, ok);
        compared++; if ({ok, id, resp, waits} !== {1'b1, 4'h2, 2'b00, 32'd0}) begin
            mismatched++; $display("FAIL b_after_hold ok=%b bid=%h bresp=%b waits=%0d want 1/2/00/0", ok, id, resp, waits); end
        $display("write id=2 addr=0x40 len=0 bresp=%b after backpressure", resp);
    endtask

    task automatic test_simultaneous();
        bit ok; logic [3:0] we, id; logic [9:0] a; int waits; logic [1:0] resp; logic [31:0] d; logic last;
        awid = 4'h6; awaddr = 32'h80; awlen = 8'd0; awvalid = 1'b1;
        arid = 4'h7; araddr = 32'h80; arlen = 8'd0; arvalid = 1'b1;
        #1;
        compared++; if ({awready, arready} !== 2'b10) begin
            mismatched++; $display("FAIL simul_arb awready=%b arready=%b want 1/0", awready, arready); end
        @(posedge clk); #1;
        awvalid = 1'b0;
        #1;
        compared++; if (arready !== 1'b0) begin mismatched++; $display("FAIL simul_busy arready=%b want=0", arready); end
        w_send(32'h12345678, 4'hF, 1'b1, we, a, waits, ok);
        b_recv(id, resp, waits, ok);
        compared++; if ({ok, id} !== {1'b1, 4'h6}) begin
            mismatched++; $display("FAIL simul_b ok=%b bid=%h want 1/6", ok, id); end
        #1;
        compared++; if (arready !== 1'b1) begin mismatched++; $display("FAIL simul_ar_next arready=%b want=1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        r_recv(d, id, resp, last, waits, ok);
        compared++; if ({ok, d, id, last, waits} !== {1'b1, 32'h12345678, 4'h7, 1'b1, 32'd2}) begin
            mismatched++; $display("FAIL simul_r ok=%b rdata=%h rid=%h rlast=%b waits=%0d want 1/12345678/7/1/2",
                                   ok, d, id, last, waits); end
        $display("write id=6 then read id=7 addr=0x80 rdata=%h", d);
    endtask

    task automatic test_reset_mid_burst();
        bit ok; logic [3:0] we, id; logic [9:0] a; int waits; logic [1:0] resp; logic [31:0] d; logic last;
        aw_send(4'h4, 32'h100, 8'd7, ok);
        w_send(32'hA0A0A0A0, 4'hF, 1'b0, we, a, waits, ok);
        w_send(32'hA1A1A1A1, 4'hF, 1'b0, we, a, waits, ok);
        wdata = 32'hA2A2A2A2; wstrb = 4'hF; wvalid = 1'b1; rstn = 1'b0;
        @(posedge clk); #1;
        compared++; if ({awready, arready, wready, bvalid, rvalid} !== 5'd0) begin
            mismatched++; $display("FAIL midrst_ctrl got=%b want=00000", {awready, arready, wready, bvalid, rvalid}); end
        rstn = 1'b1; wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if ({bvalid, rvalid} !== 2'b00) begin
            mismatched++; $display("FAIL midrst_no_resp bvalid=%b rvalid=%b want 0/0", bvalid, rvalid); end
        ar_send(4'hA, 32'h10, 8'd0, ok);
        r_recv(d, id, resp, last, waits, ok);
        compared++; if ({ok, d, id, resp, last} !== {1'b1, 32'hDEADBEEF, 4'hA, 2'b00, 1'b1}) begin
            mismatched++; $display("FAIL midrst_read ok=%b rdata=%h rid=%h rresp=%b rlast=%b want 1/deadbeef/a/00/1",
                                   ok, d, id, resp, last); end
        $display("read after reset id=a addr=0x10 rdata=%h", d);
    endtask

    task automatic test_range();
        bit ok; logic [3:0] id; int waits, re0; logic [1:0] resp, exp_resp; logic [31:0] d; logic last;
        logic [31:0] exp [2];
        int exp_reads;
`ifdef RIP_AXI_SLAVE_RANGE_CHECK_EN
        exp[0] = 32'h0; exp[1] = 32'h0; exp_resp = 2'b10; exp_reads = 0;
`else
        exp[0] = 32'h11111111; exp[1] = 32'h00000022; exp_resp = 2'b00; exp_reads = 2;
`endif
        re0 = re_count;
        ar_send(4'h1, 32'h1000, 8'd1, ok);
        for (int i = 0; i < 2; i++) begin
            r_recv(d, id, resp, last, waits, ok);
            compared++; if ({ok, d, resp, last, waits} !== {1'b1, exp[i], exp_resp, i == 1, 32'd2}) begin
                mismatched++; $display("FAIL range_r%0d ok=%b rdata=%h rresp=%b rlast=%b waits=%0d want 1/%h/%b/%0d/2",
                                       i, ok, d, resp, last, waits, exp[i], exp_resp, i == 1); end
            $display("read beat %0d id=1 addr=0x1000 rdata=%h rresp=%b", i, d, resp);
        end
        compared++; if (re_count - re0 !== exp_reads) begin
            mismatched++; $display("FAIL range_reads got=%0d want=%0d", re_count - re0, exp_reads); end
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_burst_backpressure();
        test_b_backpressure();
        test_simultaneous();
        test_reset_mid_burst();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
